parking_allocator: RTL

- Upstream stage of the parking token path.
- Tracks occupancy of the 8 parking spaces and handles entry requests with a level handshake.
- On each entry, allocates the lowest-numbered free space and presents it as `park_number` together with the current `pattern`; `token_production` consumes both.
- Processes exit requests, which free spaces.

---
 rtl/parking_allocator.sv | 119 +++++++++++
 1 files changed

// File: rtl/parking_allocator.sv
// -----------------------------------------------------------------------------
// parking_allocator
//
// Upstream stage of the parking token path. Tracks occupancy of 8 parking
// spaces, serves entry requests (level handshake on car_in / grant) by
// allocating the lowest-numbered free space, and frees spaces on exit pulses.
// The allocated space number and the current pattern are handed to
// token_production while grant is high.
//
// Optional feature: define PATTERN_ROTATE_EN to rotate pattern left by one
// on the edge that ends each GRANT cycle. Without it, pattern is constant.
//
// Ports:
//   clk          in   1  system clock, rising edge
//   rst_n        in   1  asynchronous active-low reset
//   car_in       in   1  entry request, level, held until grant is seen
//   car_out      in   1  exit request, single-cycle pulse
//   exit_number  in   3  space being vacated, valid with car_out
//   park_number  out  3  allocated space, held until the next allocation
//   pattern      out  3  pattern presented to token_production
//   grant        out  1  one-cycle pulse, park_number newly allocated
//   full         out  1  all 8 spaces occupied
//   empty        out  1  no space occupied
//   free_count   out  4  number of free spaces, 0..8
//   err          out  1  one-cycle pulse, exit of an unoccupied space
// -----------------------------------------------------------------------------
module parking_allocator #(
  parameter logic [2:0] PATTERN_INIT = 3'b101
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       car_in,
  input  logic       car_out,
  input  logic [2:0] exit_number,
  output logic [2:0] park_number,
  output logic [2:0] pattern,
  output logic       grant,
  output logic       full,
  output logic       empty,
  output logic [3:0] free_count,
  output logic       err
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SEARCH    = 2'd1;
  localparam logic [1:0] GRANT     = 2'd2;
  localparam logic [1:0] WAIT_DROP = 2'd3;

  logic [1:0] state;
  logic [1:0] state_next;
  logic [7:0] occ;
  logic [7:0] occ_next;
  logic [2:0] lowest_free;
  logic [3:0] occ_count;

  // Lowest-index free space. Scanning from the top lets the last hit win.
  // NOTE: every combinational output gets a default before any conditional
  // assignment so no latch is inferred.
  always_comb begin
    lowest_free = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!occ[i]) lowest_free = 3'(i);
    end
  end

  always_comb begin
    occ_count = 4'd0;
    for (int i = 0; i < 8; i++) begin
      occ_count = occ_count + {3'b000, occ[i]};
    end
  end

  assign free_count = 4'd8 - occ_count;
  assign full       = (free_count == 4'd0);
  assign empty      = (free_count == 4'd8);
  // Decoded from state so an asynchronous reset removes it immediately.
  assign grant      = (state == GRANT);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (car_in && !full) state_next = SEARCH;
      SEARCH:    state_next = GRANT;
      GRANT:     state_next = WAIT_DROP;
      WAIT_DROP: if (!car_in) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Allocation and exit are independent updates to occ. SEARCH is only
  // entered when a free space exists, and an exit can never clear the bit
  // being allocated because that bit was free (such an exit raises err).
  always_comb begin
    occ_next = occ;
    if (state == SEARCH) occ_next[lowest_free] = 1'b1;
    if (car_out && occ[exit_number]) occ_next[exit_number] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      occ         <= 8'd0;
      park_number <= 3'd0;
      pattern     <= PATTERN_INIT;
      err         <= 1'b0;
    end else begin
      state <= state_next;
      occ   <= occ_next;
      err   <= car_out && !occ[exit_number];
      if (state == SEARCH) park_number <= lowest_free;
`ifdef PATTERN_ROTATE_EN
      if (state == GRANT) pattern <= {pattern[1:0], pattern[2]};
`endif
    end
  end

endmodule
